// File: rtl/pwm_peripheral.sv
// pwm_peripheral: prescaled 8-bit PWM driving 16 enable-gated output lines.
// Define PWM_DUTY_SHADOW_EN to latch the duty value once per period.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);

  logic [15:0] div_cnt_q, div_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [15:0] out_q, out_d;
  logic        period_start_q, period_start_d;
  logic        tick;
  logic        wrap;
  logic [7:0]  duty_eff;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign tick = (div_cnt_q == DivLast);
  assign wrap = tick && (pwm_cnt_q == 8'hFF);

  assign div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
  assign pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  assign period_start_d = wrap;

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_q, duty_d;

  // Only the period boundary may change the duty in use.
  assign duty_d = wrap ? pwm_duty_cycle : duty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= 8'h00;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_eff = duty_q;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  // 0xFF must mean fully high, which a plain compare cannot reach.
  assign pwm_sig = (duty_eff == 8'hFF) || (pwm_cnt_q < duty_eff);

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign out_d  = en_out & (~en_pwm | {16{pwm_sig}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q      <= 16'd0;
      pwm_cnt_q      <= 8'd0;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      div_cnt_q      <= div_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed and random stimulus against a cycle-index
// reference model of the shared PWM waveform and per-line gating.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int PER     = 256 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        ps;

  int          vectors = 0;
  int          miss = 0;
  int          n = 0;
  logic [7:0]  shadow = 8'h00;
  int          mon_bit = 0;
  int          hi_acc = 0;
  int          last_hi = 0;
  int          first_ps;
  logic        exp_mid;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (ps)
  );

  always #50 clk = ~clk;

  function automatic logic [15:0] model_out(
    input logic [15:0] e, input logic [15:0] p,
    input logic [7:0] d, input int cnt);
    logic sig;
    logic [15:0] r;
    sig = (d == 8'hFF) || (cnt < int'(d));
    for (int i = 0; i < 16; i++)
      r[i] = e[i] ? (p[i] ? sig : 1'b1) : 1'b0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s n=%0d got %h exp %h", tag, n, got, exp);
    end
  endtask

  // One clock: predict from pre-edge inputs, clock, then compare.
  task automatic cyc();
    logic [15:0] eo;
    logic        ep;
    logic [7:0]  sh_n;
    logic [7:0]  d_eff;
    int          ph;
    ph = n % PER;
`ifdef PWM_DUTY_SHADOW_EN
    d_eff = shadow;
`else
    d_eff = duty;
`endif
    eo   = model_out({eo_hi, eo_lo}, {ep_hi, ep_lo}, d_eff,
                     (n / CLK_DIV) % 256);
    ep   = (ph == PER - 1);
    sh_n = ep ? duty : shadow;
    @(posedge clk);
    n++;
    shadow = sh_n;
    #1;
    chk("out", 32'(out), 32'(eo));
    chk("period_start", 32'(ps), 32'(ep));
    if (n % PER == 0) begin
      last_hi = hi_acc;
      hi_acc  = 0;
    end
    hi_acc += int'(out[mon_bit]);
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic sync();
    for (int i = 0; i < PER + 1 && (n % PER) != 0; i++) cyc();
    chk("sync", 32'(n % PER), 32'd0);
  endtask

  task automatic set_all(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d2,
                         input logic [7:0] du);
    eo_lo = a; eo_hi = b; ep_lo = c; ep_hi = d2; duty = du;
  endtask

  initial begin
    rst = 1'b1;
    set_all(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_ps", 32'(ps), 32'h0);

    rst = 1'b0;
    n = 0; shadow = 8'h00; hi_acc = 0;
    set_all(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    first_ps = -1;
    for (int i = 0; i < PER + 20; i++) begin
      cyc();
      if (ps === 1'b1 && first_ps < 0) first_ps = n;
    end
    chk("first_ps", 32'(first_ps), 32'(PER));

    set_all(8'h0F, 8'h00, 8'h00, 8'h00, 8'h00);
    cyc();
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("static_hi", 32'(out), 32'h000F);
    end

    mon_bit = 0;
    set_all(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80);
    sync();
    run(PER);
    run(PER);
    chk("duty50", 32'(last_hi), 32'(128 * CLK_DIV));

    duty = 8'h00;
    sync();
    run(PER);
    for (int k = 0; k < 3; k++) begin
      run(PER);
      chk("duty00", 32'(last_hi), 32'd0);
    end

    duty = 8'hFF;
    run(PER);
    for (int k = 0; k < 3; k++) begin
      run(PER);
      chk("dutyFF", 32'(last_hi), 32'(PER));
    end

    mon_bit = 13;
    set_all(8'h00, 8'hF0, 8'h00, 8'h30, 8'h40);
    run(PER);
    run(PER);
    chk("mixed_pwm", 32'(last_hi), 32'(64 * CLK_DIV));
    chk("mixed_static", 32'(out[15:14]), 32'h3);
    chk("mixed_off", 32'(out[11:8]), 32'h0);

    mon_bit = 0;
    set_all(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h20);
    run(PER);
    run(PER);
    for (int i = 0; i < PER && (n % PER) != 100 * CLK_DIV; i++) cyc();
    duty = 8'hC0;
    cyc();
`ifdef PWM_DUTY_SHADOW_EN
    exp_mid = 1'b0;
`else
    exp_mid = 1'b1;
`endif
    chk("mid_change", 32'(out[0]), 32'(exp_mid));
    sync();
`ifdef PWM_DUTY_SHADOW_EN
    chk("mid_cur", 32'(last_hi), 32'(32 * CLK_DIV));
`else
    chk("mid_cur", 32'(last_hi), 32'(32 * CLK_DIV + 92 * CLK_DIV));
`endif
    run(PER);
    chk("mid_next", 32'(last_hi), 32'(192 * CLK_DIV));

    for (int s = 0; s < 30; s++) begin
      set_all(8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom));
      run(int'($urandom_range(5, 60)));
    end

    set_all(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    run(40);
    #20;
    rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_ps", 32'(ps), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0; shadow = 8'h00; hi_acc = 0;
    set_all(8'h00, 8'h00, 8'hFF, 8'hFF, 8'h10);
    eo_lo = 8'hFF;
    run(300);
    for (int s = 0; s < 10; s++) begin
      set_all(8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom));
      run(int'($urandom_range(5, 60)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Generates 16 PWM-capable output lines from the configuration registers written over SPI by `spi_peripheral`. Sits directly downstream of it: consumes the output-enable, PWM-enable and duty-cycle bytes and drives the 16 chip outputs (`uo_out` = bits 7:0, `uio_out` = bits 15:8). A free-running prescaler and an 8-bit period counter produce a single shared PWM waveform; each line is forced low, held high, or PWM-modulated according to its enable bits.

## Interface

- `CLK_DIV`, default 13: prescaler divide ratio; legal 1..65535. At 10 MHz this gives a ≈3.0 kHz PWM period.
- `clk`  input  1  system clock, 10 MHz nominal, same domain as `spi_peripheral`.
- `rst`  input  1  asynchronous, active-high reset.
- `en_reg_out_7_0`  input  8  output enable, lines 7:0.
- `en_reg_out_15_8`  input  8  output enable, lines 15:8.
- `en_reg_pwm_7_0`  input  8  PWM mode select, lines 7:0.
- `en_reg_pwm_15_8`  input  8  PWM mode select, lines 15:8.
- `pwm_duty_cycle`  input  8  shared duty value, 0x00 = 0 %, 0xFF = 100 %.
- `out`  output  16  registered output lines; bit i is line i.
- `period_start`  output  1  one-cycle pulse at the start of each PWM period.

## Operation

- Prescaler `div_cnt`: counts 0..CLK_DIV-1 and wraps. `tick` is asserted in the cycle where `div_cnt == CLK_DIV-1`.
- Period counter `pwm_cnt` (8 bit): increments on `tick` and wraps 255→0. A period is 256 ticks, i.e. 256·CLK_DIV clocks (3328 at the default).
- `period_start` is registered. It pulses for one cycle in the cycle after `pwm_cnt` wraps 255→0.
- Effective duty `duty_eff`: see Configuration.
- Shared waveform:
  - `pwm_sig = 1` when `duty_eff == 8'hFF`;
  - otherwise `pwm_sig = (pwm_cnt < duty_eff)`, unsigned 8-bit compare.
  - High time per period is therefore `duty_eff` ticks for 0..254, and the full period for 255.
- Per line i, with `E` = concatenated output enable and `P` = concatenated PWM enable:
  - `E[i]=0` → next `out[i]=0`, regardless of `P[i]`;
  - `E[i]=1, P[i]=0` → `out[i]=1` (static high);
  - `E[i]=1, P[i]=1` → `out[i]=pwm_sig`.
- Enable inputs are never shadowed. They take effect on the next clock edge.
- Duty 0x00 with PWM enabled gives a constant low; no glitch pulse at wrap.
- No state machine beyond the two counters. Both counters run continuously and never stop or restart on register writes.

## Timing

- Reset (asynchronous assert, synchronous release on the `clk` edge): `div_cnt=0`, `pwm_cnt=0`, `out=16'h0000`, `period_start=0`, shadow duty = 0x00.
- Reset asserted mid-period clears everything immediately. The waveform restarts at `pwm_cnt=0` on the first clock after release.
- `out` is a register: 1-cycle latency from `pwm_cnt`/enable change to pin.
- First `tick` occurs in cycle CLK_DIV-1 after reset release.
- `CLK_DIV=1`: `tick` is asserted every cycle; the period is 256 clocks.

## Configuration

- Macro: `PWM_DUTY_SHADOW_EN`.
- Defined:
  - `pwm_duty_cycle` is sampled into a shadow register only in the cycle where `tick && pwm_cnt==255`, i.e. at the period boundary.
  - `duty_eff` = shadow, so each period uses exactly one duty value with no mid-period glitches.
  - After reset, `duty_eff` = 0x00 until the first wrap.
- Undefined:
  - `duty_eff = pwm_duty_cycle` directly.
  - A duty change takes effect within the current period, visible on `out` 1 cycle later.

## Test plan

- Reset: hold `rst`=1 with all inputs 0xFF → `out==16'h0000`, `period_start==0`. Release → `period_start` first pulses 3328 clocks later (CLK_DIV=13).
- Static high: `en_reg_out_7_0=8'h0F`, `en_reg_pwm_7_0=8'h00`, others 0 → `out==16'h000F` constantly, one cycle after the inputs settle.
- Duty 50 %: all enables 0xFF, `pwm_duty_cycle=8'h80` → each line high 128·13=1664 clocks per 3328-clock period.
- Duty extremes:
  - `pwm_duty_cycle=8'h00` → PWM lines never high across 3 periods.
  - `pwm_duty_cycle=8'hFF` → PWM lines never low across 3 periods.
- Mixed enables: `en_reg_out_15_8=8'hF0`, `en_reg_pwm_15_8=8'h30`, duty 0x40 → `out[15:14]` static 1, `out[13:12]` 25 % PWM, `out[11:8]` 0.
- Duty change mid-period at `pwm_cnt==100`, 0x20→0xC0:
  - with `PWM_DUTY_SHADOW_EN` → the current period stays 32 ticks high, the next is 192;
  - without it → the line rises again within the same period, one clock after the change.
